// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared definitions for the instruction/data memory arbiter.
//   state_e  - arbiter FSM encoding (IDLE=00, BUSY=01, RESP=10)
//   owner_e  - which requester holds the current memory transaction
//   MaxDmBurstDefault - default limit on back-to-back data grants while fetch waits
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StBusy = 2'b01,
        StResp = 2'b10
    } state_e;

    typedef enum logic {
        OwnIf = 1'b0,
        OwnDm = 1'b1
    } owner_e;

    localparam int unsigned MaxDmBurstDefault = 4;
    // Wide enough for the largest legal burst limit (15).
    localparam int unsigned StreakW = 4;

endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between instruction fetch (IF) and
// data access (DM). Requests are sampled only in IDLE, the winner's address/we/wdata
// are registered onto mem_*, the FSM waits in BUSY for mem_ack and then pulses the
// winner's ready for one cycle in RESP. DM wins ties unless it has already taken
// MAX_DM_BURST consecutive grants while fetch was waiting.
//
// Ports:
//   clk, reset                  - clock, asynchronous active-high reset
//   if_req/if_addr              - fetch request, address
//   if_rdata/if_ready           - fetched word, one-cycle completion pulse
//   dm_req/dm_we/dm_addr/dm_wdata - data request, store enable, address, store data
//   dm_rdata/dm_ready           - load data, one-cycle completion pulse
//   mem_req/mem_we/mem_addr/mem_wdata - memory request and registered command
//   mem_rdata/mem_ack           - memory read data, one-cycle completion
//   stall_if/stall_mem          - pipeline stall indications
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned MAX_DM_BURST = MaxDmBurstDefault
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ready,
    input  logic        dm_req,
    input  logic        dm_we,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    output logic [31:0] dm_rdata,
    output logic        dm_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        stall_if,
    output logic        stall_mem
);

    localparam logic [StreakW-1:0] MaxStreak = StreakW'(MAX_DM_BURST);

    state_e              state_q, state_d;
    owner_e              owner_q, owner_d;
    logic [StreakW-1:0]  streak_q, streak_d;
    logic                mem_we_q, mem_we_d;
    logic [31:0]         mem_addr_q, mem_addr_d;
    logic [31:0]         mem_wdata_q, mem_wdata_d;
    logic [31:0]         if_rdata_q, if_rdata_d;
    logic [31:0]         dm_rdata_q, dm_rdata_d;
    logic                grant_dm;

    // DM wins unless fetch is waiting and DM has used up its burst allowance.
    assign grant_dm = dm_req & ~(if_req & (streak_q == MaxStreak));

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        streak_d    = streak_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_rdata_d  = if_rdata_q;
        dm_rdata_d  = dm_rdata_q;

        case (state_q)
            StIdle: begin
                if (if_req || dm_req) begin
                    state_d = StBusy;
                    if (grant_dm) begin
                        owner_d     = OwnDm;
                        mem_we_d    = dm_we;
                        mem_addr_d  = dm_addr;
                        mem_wdata_d = dm_wdata;
                        if (!if_req) begin
                            streak_d = '0;
                        end else if (streak_q != MaxStreak) begin
                            streak_d = streak_q + StreakW'(1);
                        end
                    end else begin
                        // Fetch is a read; write data register is left untouched.
                        owner_d    = OwnIf;
                        mem_we_d   = 1'b0;
                        mem_addr_d = if_addr;
                        streak_d   = '0;
                    end
                end
            end
            StBusy: begin
                if (mem_ack) begin
                    state_d = StResp;
                    if (owner_q == OwnIf) begin
                        if_rdata_d = mem_rdata;
                    end else if (!mem_we_q) begin
                        dm_rdata_d = mem_rdata;
                    end
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            owner_q     <= OwnIf;
            streak_q    <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            streak_q    <= streak_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_rdata_q  <= if_rdata_d;
            dm_rdata_q  <= dm_rdata_d;
        end
    end

    // Decoded straight from state so a reset drops mem_req and ready without a clock.
    assign mem_req   = (state_q == StBusy);
    assign if_ready  = (state_q == StResp) && (owner_q == OwnIf);
    assign dm_ready  = (state_q == StResp) && (owner_q == OwnDm);
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign if_rdata  = if_rdata_q;
    assign dm_rdata  = dm_rdata_q;
    assign stall_if  = if_req & ~if_ready;
    assign stall_mem = dm_req & ~dm_ready;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: MAX_DM_BURST, 4, max consecutive data-port grants while fetch waits; legal range 1..15.
REQ-002 Port: clk  in  1  single clock; all state changes on its rising edge.
REQ-003 Port: reset  in  1  asynchronous, active-high reset.
REQ-004 Port: if_req  in  1  fetch-stage read request; held until if_ready.
REQ-005 Port: if_addr  in  32  fetch address; stable while if_req=1.
REQ-006 Port: if_rdata  out  32  fetched instruction; valid when if_ready=1.
REQ-007 Port: if_ready  out  1  one-cycle fetch completion pulse.
REQ-008 Port: dm_req  in  1  MEM-stage access request; held until dm_ready.
REQ-009 Port: dm_we  in  1  1=store, 0=load; stable while dm_req=1.
REQ-010 Port: dm_addr  in  32  data address; stable while dm_req=1.
REQ-011 Port: dm_wdata  in  32  store data; stable while dm_req=1.
REQ-012 Port: dm_rdata  out  32  load data; valid when dm_ready=1.
REQ-013 Port: dm_ready  out  1  one-cycle data completion pulse.
REQ-014 Port: mem_req  out  1  request to the shared single-port memory.
REQ-015 Port: mem_we  out  1  write enable to memory.
REQ-016 Port: mem_addr  out  32  registered memory address.
REQ-017 Port: mem_wdata  out  32  registered memory write data.
REQ-018 Port: mem_rdata  in  32  memory read data; valid in the mem_ack cycle.
REQ-019 Port: mem_ack  in  1  one-cycle memory completion; arbitrary latency >=1 cycle after mem_req rises.
REQ-020 Port: stall_if  out  1  if_req & ~if_ready; freezes PC/IF-ID.
REQ-021 Port: stall_mem  out  1  dm_req & ~dm_ready; freezes whole pipeline.

Function
REQ-022 FSM states IDLE, BUSY, RESP; owner register records IF or DM grant.
REQ-023 IDLE: no request -> stay; else grant per REQ-024, latch addr/we/wdata into mem_* registers, go BUSY.
REQ-024 Arbitration: DM only -> DM; IF only -> IF; both -> DM unless dm_streak==MAX_DM_BURST, then IF.
REQ-025 dm_streak: +1 on a DM grant while if_req=1 (saturates at MAX_DM_BURST); cleared on any IF grant or when if_req=0 at DM grant.
REQ-026 Fetch grant: mem_we=0 and mem_wdata unchanged.
REQ-027 BUSY: mem_req=1, mem_* registers stable; on mem_ack capture mem_rdata into owner's rdata register (load/fetch only), go RESP.
REQ-028 Store: dm_rdata holds previous value; ack still produces dm_ready.
REQ-029 RESP: owner's ready=1 for exactly one cycle, mem_req=0, then IDLE.
REQ-030 Requests are sampled only in IDLE; requester drops req on the edge where ready=1; a req held past that edge is a new request.
REQ-031 Latency: req in IDLE cycle 0 -> mem_req cycles 1..k (ack in k) -> ready in k+1; back-to-back min 3 cycles per access.
REQ-032 mem_ack outside BUSY is ignored; req changes during BUSY/RESP do not alter the current transaction.
REQ-033 if_rdata/dm_rdata hold last captured value until next capture.

Reset
REQ-034 Reset asserted: state=IDLE, owner=IF, dm_streak=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, if_rdata=0, dm_rdata=0, if_ready=0, dm_ready=0, immediately (no clock).
REQ-035 Reset mid-BUSY/RESP aborts: no ready pulse; a later mem_ack is ignored.

Structure
REQ-036 Shared package holds FSM state encoding (IDLE=2'b00, BUSY=2'b01, RESP=2'b10), owner encoding, and MAX_DM_BURST default.
REQ-037 Single flat module; no sub-module.

Verification
REQ-038 IF-only read 0x0000_0040, ack latency 2, mem_rdata=0x2008_0005 -> mem_req cycles 1-2, if_ready cycle 3, if_rdata=0x2008_0005.
REQ-039 IF and DM load 0x100 raised same cycle -> DM granted first, dm_ready then IF serviced, stall_if high throughout.
REQ-040 dm_req held continuously with if_req, MAX_DM_BURST=4 -> exactly 4 DM grants, 5th grant to IF, dm_streak=0 after.
REQ-041 Store addr 0x200 data 0xDEAD_BEEF -> mem_we=1, mem_wdata=0xDEAD_BEEF, dm_ready pulse, dm_rdata unchanged.
REQ-042 Reset asserted in BUSY, ack arrives next cycle -> mem_req drops asynchronously, no if_ready/dm_ready, FSM IDLE.
REQ-043 Spurious mem_ack in IDLE with no requests -> no ready, outputs unchanged.
